uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N_REQ byte-sources (CPU MMIO, debug

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
// The state type is exported so debug logic and benches can decode Arb_state_out.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_STOP = 3'd3,
    WAIT_END  = 3'd4,
    DONE      = 3'd5
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr_i, wrapping from N_REQ-1 back to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    win_o,
  output logic             valid_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one is written last.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_i) + i) % N_REQ);
      if (req_i[idx]) begin
        win_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// Handshake: req_i is a level held until done_o; the winner sees grant_o for the whole frame.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [N_REQ-1:0]            done_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        tx_send,
  output logic [DATA_WIDTH-1:0]       Tx_Data,
  input  logic                        tx_fsm_in_STOP_S,
  output arb_state_t                  Arb_state_out
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  send_q, send_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;

  logic [IW-1:0]         pick_win;
  logic                  pick_valid;
  logic [IW-1:0]         rr_next;
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  assign rr_next = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    grant_d  = grant_q;
    txd_d    = txd_q;
    done_d   = '0;
    err_d    = 1'b0;
    send_d   = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        win_d           = pick_win;
        grant_d         = '0;
        grant_d[pick_win] = 1'b1;
        state_d         = LOAD;
      end
      LOAD: begin
        txd_d   = data_arr[win_q];
        send_d  = 1'b1;
        wd_d    = '0;
        state_d = SEND;
      end
      SEND:      state_d = WAIT_STOP;
      WAIT_STOP: if (tx_fsm_in_STOP_S) state_d = WAIT_END;
      WAIT_END: if (!tx_fsm_in_STOP_S) begin
        done_d   = grant_q;
        grant_d  = '0;
        rr_ptr_d = rr_next;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The watchdog spans SEND through WAIT_END and overrides normal completion.
    if (state_q == SEND || state_q == WAIT_STOP || state_q == WAIT_END) begin
      if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
        state_d  = IDLE;
        err_d    = 1'b1;
        done_d   = '0;
        grant_d  = '0;
        rr_ptr_d = rr_next;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      send_q   <= 1'b0;
      txd_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      send_q   <= send_d;
      txd_q    <= txd_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign tx_send       = send_q;
  assign Tx_Data       = txd_q;
  assign Arb_state_out = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a reference round-robin model plus a simple
// transmitter STOP-flag model driven per transaction.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int T  = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_i = '0;
  logic [N*DW-1:0]   data_i = '0;
  logic [N-1:0]      grant_o, done_o;
  logic              err_o, busy_o, tx_send;
  logic [DW-1:0]     Tx_Data;
  logic              stop = 1'b0;
  arb_state_t        st;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;
  logic [DW-1:0] exp_q[$];

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYC(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req_i),
    .data_i           (data_i),
    .grant_o          (grant_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o),
    .tx_send          (tx_send),
    .Tx_Data          (Tx_Data),
    .tx_fsm_in_STOP_S (stop),
    .Arb_state_out    (st)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(rr_m + i) % N]) return (rr_m + i) % N;
    return -1;
  endfunction

  // Called in an IDLE cycle. mode: 0 normal frame, 1 stale STOP at send, 2 hung transmitter.
  task automatic run_txn(input logic [N-1:0] req, input int mode, input bit drop,
                         input logic [N-1:0] next_req);
    int k, cyc, lo, hi;
    k = model_pick(req);
    exp_q.push_back(data_i[k*DW +: DW]);
    req_i = req;
    stop  = (mode == 1);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!tx_send && cyc < 10);
    check_eq("send_latency", cyc, 2);
    check_eq("grant", grant_o, 1 << k);
    check_eq("tx_data", Tx_Data, exp_q.pop_front());
    if (drop) begin
      req_i  = '0;
      data_i = $urandom();
    end
    if (mode == 2) begin
      stop = 1'b0;
      cyc = 0;
      do begin
        tick();
        cyc++;
        check_eq("no_done_on_hang", done_o, 0);
      end while (!err_o && cyc < T + 10);
      check_eq("watchdog_latency", cyc, T);
      check_eq("err_grant", grant_o, 0);
      check_eq("err_busy", busy_o, 0);
      check_eq("err_state", st, IDLE);
      rr_m  = (k + 1) % N;
      req_i = next_req;
    end else begin
      if (mode == 0) begin
        stop = 1'b0;
        lo = $urandom_range(1, 5);
        repeat (lo) begin
          tick();
          check_eq("hold_grant", grant_o, 1 << k);
          check_eq("early_done", done_o, 0);
          check_eq("single_send", tx_send, 0);
        end
      end
      stop = 1'b1;
      hi = (mode == 1) ? $urandom_range(2, 4) : $urandom_range(1, 4);
      repeat (hi) begin
        tick();
        check_eq("hold_grant_stop", grant_o, 1 << k);
        check_eq("early_done_stop", done_o, 0);
      end
      stop = 1'b0;
      tick();
      check_eq("done", done_o, 1 << k);
      check_eq("grant_released", grant_o, 0);
      check_eq("done_no_send", tx_send, 0);
      rr_m  = (k + 1) % N;
      req_i = next_req;
      tick();
      check_eq("done_pulse", done_o, 0);
      check_eq("idle_busy", busy_o, 0);
      check_eq("idle_state", st, IDLE);
    end
  endtask

  initial begin
    logic [N-1:0] rq [17];
    int cyc;
    repeat (3) tick();
    check_eq("rst_state", st, IDLE);
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_txd", Tx_Data, 0);
    check_eq("rst_send", tx_send, 0);
    rst = 1'b0;
    tick();

    // All requesting from reset: frames 11,22,33,44,11.
    data_i = 32'h44332211;
    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, 0, 1'b0, (i < 4) ? 4'b1111 : 4'b0000);

    data_i = 32'h0000A500;
    run_txn(4'b0010, 0, 1'b0, 4'b0000);

    // Grant to 2, then 0101 must wrap to 0 before 2 again.
    data_i = $urandom();
    run_txn(4'b0100, 0, 1'b0, 4'b0101);
    run_txn(4'b0101, 0, 1'b0, 4'b0101);
    run_txn(4'b0101, 1, 1'b0, 4'b0000);

    data_i = $urandom();
    run_txn(4'b1000, 0, 1'b1, 4'b0000);
    data_i = $urandom();
    run_txn(4'b0011, 2, 1'b0, 4'b0000);

    // Reset in WAIT_STOP.
    data_i = $urandom();
    req_i  = 4'b0100;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!tx_send && cyc < 10);
    check_eq("pre_rst_send", cyc, 2);
    stop = 1'b0;
    tick();
    check_eq("pre_rst_state", st, WAIT_STOP);
    rst   = 1'b1;
    req_i = '0;
    tick();
    check_eq("mid_rst_state", st, IDLE);
    check_eq("mid_rst_grant", grant_o, 0);
    check_eq("mid_rst_done", done_o, 0);
    check_eq("mid_rst_err", err_o, 0);
    check_eq("mid_rst_send", tx_send, 0);
    check_eq("mid_rst_txd", Tx_Data, 0);
    check_eq("mid_rst_busy", busy_o, 0);
    rst  = 1'b0;
    rr_m = 0;
    tick();
    data_i = $urandom();
    run_txn(4'b1111, 0, 1'b0, 4'b0000);

    for (int i = 0; i < 17; i++) rq[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) begin
      data_i = $urandom();
      run_txn(rq[i], ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1),
              1'($urandom_range(0, 1)), rq[i+1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
